// File: rtl/sd_adc_decimator_pkg.sv
// Shared constants for the sigma-delta ADC front end and its downstream PWM range mapping.
// Holds the default widths and the full-scale sample value helper.
package sd_adc_pkg;

  localparam int unsigned CNT_W_DEFAULT        = 10;
  localparam int unsigned SYNC_STAGES_DEFAULT  = 2;
  localparam int unsigned SMOOTH_SHIFT_DEFAULT = 2;

  // Largest representable sample for a given count width (2^width - 1).
  function automatic int unsigned sat_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/sd_adc_decimator_sync_2ff.sv
// Multi-flop synchroniser for a single asynchronous input pin.
// STAGES selects the chain depth (2 or 3); output lags the input by STAGES clocks.
module sync_2ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/sd_adc_decimator.sv
// First-order sigma-delta front end: comparator sync, 1-bit feedback, windowed
// ones-count with saturation, and an exponential smoothing filter on the samples.
module sd_adc_decimator
  import sd_adc_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEFAULT,
  parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEFAULT,
  parameter int unsigned SMOOTH_SHIFT = SMOOTH_SHIFT_DEFAULT
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             comp_async_i,
  output logic             fb_o,
  output logic [CNT_W-1:0] raw_o,
  output logic             raw_valid_o,
  output logic [CNT_W-1:0] filt_o,
  output logic             filt_valid_o
);

  localparam int unsigned FW = CNT_W + SMOOTH_SHIFT;
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(sat_max(CNT_W));

  logic             comp_s;
  logic             fb_q;
  logic [CNT_W-1:0] win_cnt_q;
  logic [CNT_W:0]   acc_q;
  logic [CNT_W-1:0] raw_q;
  logic             raw_valid_q;
  logic [FW-1:0]    filt_q;
  logic [CNT_W-1:0] filt_out_q;
  logic             filt_valid_q;
  logic             first_q;

  logic             terminal;
  logic [CNT_W:0]   tot;
  logic [CNT_W-1:0] tot_sat;
  logic [FW:0]      fq_ext;
  logic [FW:0]      raw_ext;
  logic [FW-1:0]    filt_upd;
  logic [FW-1:0]    filt_preload;
  logic [FW-1:0]    filt_nxt;

  sync_2ff #(
    .STAGES (SYNC_STAGES)
  ) u_comp_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (comp_async_i),
    .q_o     (comp_s)
  );

  // A window only closes while the converter is running; a disable in the
  // terminal cycle throws the window away.
  always_comb begin
    terminal = 1'b0;
    tot      = '0;
    tot_sat  = '0;
    terminal = enable_i && (win_cnt_q == WIN_LAST);
    tot      = acc_q + {{CNT_W{1'b0}}, fb_q};
    // Only a full window of ones reaches bit CNT_W, which maps to full scale.
    tot_sat  = tot[CNT_W] ? WIN_LAST : tot[CNT_W-1:0];
  end

  // One spare bit keeps filt + raw from wrapping before the decay term is removed.
  always_comb begin
    fq_ext       = '0;
    raw_ext      = '0;
    filt_upd     = '0;
    filt_preload = '0;
    filt_nxt     = '0;
    fq_ext       = {1'b0, filt_q};
    raw_ext      = (FW+1)'(raw_q);
    filt_upd     = FW'(fq_ext + raw_ext - (fq_ext >> SMOOTH_SHIFT));
    filt_preload = FW'(raw_q) << SMOOTH_SHIFT;
    filt_nxt     = first_q ? filt_upd : filt_preload;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fb_q         <= 1'b0;
      win_cnt_q    <= '0;
      acc_q        <= '0;
      raw_q        <= '0;
      raw_valid_q  <= 1'b0;
      filt_q       <= '0;
      filt_out_q   <= '0;
      filt_valid_q <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      fb_q         <= comp_s & enable_i;
      raw_valid_q  <= terminal;
      filt_valid_q <= raw_valid_q;

      if (!enable_i) begin
        win_cnt_q <= '0;
        acc_q     <= '0;
      end else begin
        win_cnt_q <= win_cnt_q + CNT_W'(1);
        acc_q     <= terminal ? '0 : tot;
      end

      if (terminal) begin
        raw_q <= tot_sat;
      end

      // The filtered output is registered from the next filter value so it
      // lines up with filt_valid one cycle after the raw strobe.
      if (raw_valid_q) begin
        filt_q     <= filt_nxt;
        filt_out_q <= CNT_W'(filt_nxt >> SMOOTH_SHIFT);
      end

      if (!enable_i) begin
        first_q <= 1'b0;
      end else if (raw_valid_q) begin
        first_q <= 1'b1;
      end
    end
  end

  assign fb_o         = fb_q;
  assign raw_o        = raw_q;
  assign raw_valid_o  = raw_valid_q;
  assign filt_o       = filt_out_q;
  assign filt_valid_o = filt_valid_q;

endmodule

// File: tb/tb_sd_adc_decimator.sv
// Bench for sd_adc_decimator: directed scenarios plus randomized comparator density,
// enable gaps and resets, checked every cycle against a window-level reference model.
module tb_sd_adc_decimator;

  localparam int CW   = 4;
  localparam int SS   = 2;
  localparam int SH   = 2;
  localparam int WLEN = 1 << CW;
  localparam int WMAX = WLEN - 1;

  logic          clk_i        = 1'b0;
  logic          reset_i      = 1'b1;
  logic          enable_i     = 1'b0;
  logic          comp_async_i = 1'b0;
  logic          fb_o;
  logic [CW-1:0] raw_o;
  logic          raw_valid_o;
  logic [CW-1:0] filt_o;
  logic          filt_valid_o;

  int errors = 0;
  int checks = 0;

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  sd_adc_decimator #(
    .CNT_W        (CW),
    .SYNC_STAGES  (SS),
    .SMOOTH_SHIFT (SH)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .comp_async_i (comp_async_i),
    .fb_o         (fb_o),
    .raw_o        (raw_o),
    .raw_valid_o  (raw_valid_o),
    .filt_o       (filt_o),
    .filt_valid_o (filt_valid_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Input history: index 0 is the cycle that just ended at this edge.
  bit comp_h [8];
  bit en_h   [8];
  bit rst_h  [8];
  int fb_h [$];
  int run_pos  = 0;
  int f_acc    = 0;
  bit first_m  = 1'b0;
  bit m_valid  = 1'b0;
  int e_fb     = 0;
  int e_raw_v  = 0;
  int e_raw    = 0;
  int e_filt_v = 0;
  int e_filt   = 0;
  logic [CW-1:0] exp_q [$];

  always @(posedge clk_i) begin : model
    int  raw_v_t;
    int  raw_t;
    int  sum;
    bit  ok;
    bit  term;
    for (int i = 7; i > 0; i--) begin
      comp_h[i] = comp_h[i-1];
      en_h[i]   = en_h[i-1];
      rst_h[i]  = rst_h[i-1];
    end
    comp_h[0] = comp_async_i;
    en_h[0]   = enable_i;
    rst_h[0]  = reset_i;
    fb_h.push_back(e_fb);
    if (fb_h.size() > WLEN) void'(fb_h.pop_front());
    raw_v_t = e_raw_v;
    raw_t   = e_raw;
    if (reset_i) begin
      e_fb = 0; e_raw_v = 0; e_raw = 0; e_filt_v = 0; e_filt = 0;
      f_acc = 0; first_m = 1'b0; run_pos = 0;
      fb_h.delete();
      exp_q.delete();
      m_valid = 1'b1;
    end else begin
      // Feedback is the comparator seen SS+1 cycles ago, gated by enable, with
      // no reset anywhere along the path.
      ok = 1'b1;
      for (int i = 0; i <= SS; i++) if (rst_h[i]) ok = 1'b0;
      e_fb = (comp_h[SS] && en_h[0] && ok) ? 1 : 0;
      term = enable_i && (run_pos == WMAX);
      e_raw_v = term ? 1 : 0;
      if (term) begin
        sum = 0;
        foreach (fb_h[i]) sum += fb_h[i];
        e_raw = (sum > WMAX) ? WMAX : sum;
        exp_q.push_back(CW'(e_raw));
      end
      e_filt_v = raw_v_t;
      if (raw_v_t != 0) begin
        if (first_m) f_acc = f_acc + raw_t - (f_acc / (1 << SH));
        else         f_acc = raw_t * (1 << SH);
        e_filt = f_acc / (1 << SH);
      end
      if (!enable_i)        first_m = 1'b0;
      else if (raw_v_t != 0) first_m = 1'b1;
      run_pos = enable_i ? (run_pos + 1) % WLEN : 0;
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk_i) begin
    if (m_valid) begin
      chk("fb_o", fb_o, e_fb);
      chk("raw_valid_o", raw_valid_o, e_raw_v);
      chk("raw_o", raw_o, e_raw);
      chk("filt_valid_o", filt_valid_o, e_filt_v);
      chk("filt_o", filt_o, e_filt);
      if (raw_valid_o === 1'b1) begin
        chk("raw_strobe_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("raw_sample_q", raw_o, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic e, input logic c);
    @(posedge clk_i);
    #2;
    reset_i      = r;
    enable_i     = e;
    comp_async_i = c;
    @(negedge clk_i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int   first_k;
    int   strobes;
    int   prev_f;
    int   dens;
    int   dis_left;
    int   held_raw;
    int   held_filt;
    logic tog;

    // Test 1: constant ones from reset release.
    repeat (3) step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k <= 40; k++) begin
      step(1'b0, 1'b1, 1'b1);
      if (k == 0)  chk("t1_raw_after_reset", raw_o, 0);
      if (k == 2)  chk("t1_fb_c2", fb_o, 0);
      if (k == 3)  chk("t1_fb_c3", fb_o, 1);
      if (k == 16) begin chk("t1_rv_c16", raw_valid_o, 1); chk("t1_raw_c16", raw_o, 13); end
      if (k == 17) begin chk("t1_fv_c17", filt_valid_o, 1); chk("t1_filt_c17", filt_o, 13); end
      if (k == 32) chk("t1_raw_sat_c32", raw_o, 15);
      if (k == 33) chk("t1_filt_c33", filt_o, 13);
    end

    // Test 2: constant zeros.
    repeat (2) step(1'b1, 1'b1, 1'b0);
    strobes = 0;
    for (int k = 0; k <= 48; k++) begin
      step(1'b0, 1'b1, 1'b0);
      if (raw_valid_o === 1'b1) strobes++;
      if (k == 16) chk("t2_raw_zero", raw_o, 0);
      if (k == 17) chk("t2_filt_zero", filt_o, 0);
    end
    chk("t2_strobe_count", strobes, 3);

    // Test 3: 50% density, then Test 4: step to all ones.
    repeat (2) step(1'b1, 1'b1, 1'b0);
    tog = 1'b0;
    for (int k = 0; k <= 130; k++) begin
      step(1'b0, 1'b1, tog);
      tog = ~tog;
      if (raw_valid_o === 1'b1 && k >= 32) chk("t3_raw_range", (raw_o >= 7 && raw_o <= 9), 1);
    end
    chk("t3_converged", (filt_o >= 7 && filt_o <= 9), 1);
    repeat (5 * WLEN) begin
      step(1'b0, 1'b1, tog);
      tog = ~tog;
    end
    prev_f = e_filt;
    repeat (14 * WLEN) begin
      step(1'b0, 1'b1, 1'b1);
      if (filt_valid_o === 1'b1) begin
        chk("t4_monotonic", filt_o >= prev_f, 1);
        prev_f = e_filt;
      end
    end
    chk("t4_final", filt_o, 15);

    // Test 5: reset pulse at window position 9.
    first_k = -1;
    for (int k = 0; k < 40 && first_k < 0; k++) begin
      step(1'b0, 1'b1, tog);
      tog = ~tog;
      if (raw_valid_o === 1'b1) first_k = k;
    end
    chk("t5_align", first_k >= 0, 1);
    repeat (8) begin step(1'b0, 1'b1, tog); tog = ~tog; end
    step(1'b1, 1'b1, tog);
    first_k  = -1;
    held_raw = -1;
    for (int k = 0; k <= 40; k++) begin
      step(1'b0, 1'b1, tog);
      tog = ~tog;
      if (k == 0) begin
        chk("t5_raw_zero", raw_o, 0);
        chk("t5_filt_zero", filt_o, 0);
        chk("t5_rv_zero", raw_valid_o, 0);
      end
      if (raw_valid_o === 1'b1 && first_k < 0) begin first_k = k; held_raw = e_raw; end
      if (first_k >= 0 && k == first_k + 1) chk("t5_preload", filt_o, held_raw);
    end
    chk("t5_restart", first_k, 16);

    // Test 6: enable low for 20 cycles mid-window.
    first_k = -1;
    for (int k = 0; k < 40 && first_k < 0; k++) begin
      step(1'b0, 1'b1, tog);
      tog = ~tog;
      if (raw_valid_o === 1'b1) first_k = k;
    end
    repeat (7) begin step(1'b0, 1'b1, tog); tog = ~tog; end
    held_raw  = e_raw;
    held_filt = e_filt;
    strobes   = 0;
    repeat (20) begin
      step(1'b0, 1'b0, tog);
      tog = ~tog;
      if (raw_valid_o === 1'b1 || filt_valid_o === 1'b1) strobes++;
    end
    chk("t6_no_strobes", strobes, 0);
    chk("t6_fb_off", fb_o, 0);
    chk("t6_raw_held", raw_o, held_raw);
    chk("t6_filt_held", filt_o, held_filt);
    first_k  = -1;
    held_raw = -1;
    for (int k = 0; k <= 40; k++) begin
      step(1'b0, 1'b1, tog);
      tog = ~tog;
      if (raw_valid_o === 1'b1 && first_k < 0) begin first_k = k; held_raw = e_raw; end
      if (first_k >= 0 && k == first_k + 1) chk("t6_preload", filt_o, held_raw);
    end
    chk("t6_restart", first_k, 16);

    // Randomized density, enable gaps and occasional resets.
    dens     = 50;
    dis_left = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) == 0) dens = $urandom_range(0, 100);
      if (dis_left > 0) dis_left--;
      else if ($urandom_range(0, 199) == 0) dis_left = $urandom_range(1, 30);
      step($urandom_range(0, 399) == 0, dis_left == 0, $urandom_range(0, 99) < dens);
    end
    repeat (4) step(1'b0, 1'b1, 1'b0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
